arm7tdmi_flag_gen: RTL
======================

ARM7TDMI_FLAG_GEN -- requirements
Module: arm7tdmi_flag_gen

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port upd_valid, input, 1: flag-update beat offered.
REQ-004 SHALL have port upd_ready, output, 1: beat accepted when upd_valid && upd_ready at a clk edge.
REQ-005 SHALL have port upd_kind, input, 2: 0 logical, 1 add, 2 sub, 3 multiply.
REQ-006 SHALL have port mul_long, input, 1: multiply is 64-bit (two beats); ignored for kinds 0-2.
REQ-007 SHALL have port result, input, 32: ALU/shifter result, or multiply low word (beat 1) / high word (beat 2).
REQ-008 SHALL have port op_a, input, 32: first ALU operand, used for V.
REQ-009 SHALL have port op_b, input, 32: second ALU operand, used for V.
REQ-010 SHALL have port alu_carry, input, 1: adder carry-out; for sub this is NOT borrow.
REQ-011 SHALL have port shifter_carry, input, 1: barrel-shifter carry-out.
REQ-012 SHALL have port msr_valid, input, 1: direct flag write (MSR).
REQ-013 SHALL have port msr_flags, input, 4: {N,Z,C,V} for MSR.
REQ-014 SHALL have port flush, input, 1: pipeline flush.
REQ-015 SHALL have port cond, input, 4: ARM condition field to evaluate.
REQ-016 SHALL have port cond_pass, output, 1: cond satisfied by committed flags.
REQ-017 SHALL have ports flag_n, flag_z, flag_c, flag_v, output, 1 each: committed flags.
REQ-018 SHALL have port flags_busy, output, 1: long-multiply update in flight.

Function
REQ-019 SHALL implement FSM states IDLE and LONG_HI; flags_busy = (state == LONG_HI).
REQ-020 SHALL drive upd_ready = !msr_valid && !flush, combinationally, in both states.
REQ-021 SHALL commit an accepted non-long beat at that clk edge; new flags are visible the following cycle (latency 1).
REQ-022 Logical: N=result[31], Z=(result==0), C=shifter_carry, V unchanged.
REQ-023 Add: N, Z as logical; C=alu_carry; V=(op_a[31]==op_b[31]) && (result[31]!=op_a[31]).
REQ-024 Sub: N, Z as logical; C=alu_carry; V=(op_a[31]!=op_b[31]) && (result[31]!=op_a[31]).
REQ-025 32-bit multiply: N, Z as logical; C and V unchanged.
REQ-026 Long-multiply beat 1 accepted in IDLE: latch lo_zero=(result==0), go to LONG_HI, flags unchanged.
REQ-027 In LONG_HI, the next accepted beat is the high word regardless of upd_kind: N=result[31], Z=lo_zero && (result==0), C and V unchanged; return to IDLE.
REQ-028 LONG_HI SHALL hold indefinitely while upd_valid is low.
REQ-029 msr_valid SHALL load all four flags from msr_flags at that edge, in either state; upd_ready is low, so no update is accepted in that cycle.
REQ-030 flush in LONG_HI SHALL return to IDLE and discard lo_zero; flags unchanged.
REQ-031 flush in IDLE SHALL have no effect beyond upd_ready=0.
REQ-032 msr_valid && flush in LONG_HI: MSR is applied and the state goes to IDLE.
REQ-033 cond_pass SHALL be combinational from committed flags, independent of state:
- 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
- 8 HI C&&!Z; 9 LS !C||Z; A GE N==V; B LT N!=V
- C GT !Z&&N==V; D LE Z||N!=V; E AL 1; F NV 0

Reset
REQ-034 rst SHALL set flags N=Z=C=V=0, state IDLE, lo_zero=0, flags_busy=0, overriding msr_valid and any accepted beat in that cycle.
REQ-035 rst asserted in LONG_HI SHALL abandon the pending long multiply.

Verification
REQ-036 Release rst -> flags 0000, flags_busy 0; cond=1 gives cond_pass 1; cond=0 gives 0; cond=F gives 0.
REQ-037 Add, op_a=0x7FFFFFFF, op_b=1, result=0x80000000, alu_carry=0 -> next cycle NZCV=1001; cond A passes, cond B fails.
REQ-038 Sub, op_a=op_b=5, result=0, alu_carry=1 -> NZCV=0110; cond 0 passes, cond 8 fails, cond 9 passes.
REQ-039 Start from NZCV=0011; long multiply, beat 1 lo=0, two idle cycles, beat 2 hi=0x00000001 -> flags_busy 1 until beat 2; then NZCV=0011.
REQ-040 Long multiply beat 1 lo=0, then flush in LONG_HI -> flags unchanged; flags_busy 0 the next cycle; a following logical result=0 sets Z=1.
REQ-041 msr_valid, msr_flags=1010, with upd_valid logical result=0 in the same cycle -> upd_ready 0; NZCV=1010.

Source files
------------

// File: rtl/arm7tdmi_flag_gen.sv
// NZCV flag commit unit with condition evaluation; updates land one cycle after acceptance.
// Latency 1; a beat is refused (upd_ready low) only during an MSR write or a flush cycle.
module arm7tdmi_flag_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [1:0]  upd_kind,
  input  logic        mul_long,
  input  logic [31:0] result,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        alu_carry,
  input  logic        shifter_carry,
  input  logic        msr_valid,
  input  logic [3:0]  msr_flags,
  input  logic        flush,
  input  logic [3:0]  cond,
  output logic        cond_pass,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flags_busy
);

  typedef enum logic [0:0] {IDLE, LONG_HI} state_t;

  state_t state, state_nxt;
  logic   lo_zero, lo_zero_nxt;
  logic   n_nxt, z_nxt, c_nxt, v_nxt;
  logic   accept, res_zero, res_neg;

  assign upd_ready  = !msr_valid && !flush;
  assign accept     = upd_valid && upd_ready;
  assign flags_busy = (state == LONG_HI);
  assign res_zero   = (result == 32'd0);
  assign res_neg    = result[31];

  always_comb begin
    state_nxt   = state;
    lo_zero_nxt = lo_zero;
    n_nxt       = flag_n;
    z_nxt       = flag_z;
    c_nxt       = flag_c;
    v_nxt       = flag_v;
    if (state == LONG_HI) begin
      // The beat after a long-multiply low word is always its high word.
      if (flush) begin
        state_nxt   = IDLE;
        lo_zero_nxt = 1'b0;
      end else if (accept) begin
        n_nxt       = res_neg;
        z_nxt       = lo_zero && res_zero;
        state_nxt   = IDLE;
        lo_zero_nxt = 1'b0;
      end
    end else if (accept) begin
      case (upd_kind)
        2'd0: begin
          n_nxt = res_neg;
          z_nxt = res_zero;
          c_nxt = shifter_carry;
        end
        2'd1: begin
          n_nxt = res_neg;
          z_nxt = res_zero;
          c_nxt = alu_carry;
          v_nxt = (op_a[31] == op_b[31]) && (result[31] != op_a[31]);
        end
        2'd2: begin
          n_nxt = res_neg;
          z_nxt = res_zero;
          c_nxt = alu_carry;
          v_nxt = (op_a[31] != op_b[31]) && (result[31] != op_a[31]);
        end
        default: begin
          if (mul_long) begin
            state_nxt   = LONG_HI;
            lo_zero_nxt = res_zero;
          end else begin
            n_nxt = res_neg;
            z_nxt = res_zero;
          end
        end
      endcase
    end
    if (msr_valid) begin
      {n_nxt, z_nxt, c_nxt, v_nxt} = msr_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lo_zero <= 1'b0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lo_zero <= lo_zero_nxt;
      flag_n  <= n_nxt;
      flag_z  <= z_nxt;
      flag_c  <= c_nxt;
      flag_v  <= v_nxt;
    end
  end

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule
